// File: rtl/gf_muls_2_sched.sv
// gf_muls_2_sched: shares one GF(2^2) shared-factor multiplier (normal basis
// [Omega^2,Omega]) between NREQ requesters. Each requester has a valid/ready operand port.
// One registered result port returns the product, tagged with the index of the requester.
//
// Optional feature: define GF_MULS_2_SCHED_FIXED_PRIO_EN for fixed priority, where the
// lowest index wins and there is no round-robin pointer. It is undefined by default,
// which gives round-robin.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  per-requester operand valid
//   req_ready  per-requester grant, one-hot or zero (combinational)
//   req_a      operand A, requester i at [2i+1:2i]
//   req_ab     shared factor ab, per requester
//   req_b      operand B, requester i at [2i+1:2i]
//   req_cd     shared factor cd, per requester
//   res_valid  result valid (registered)
//   res_ready  consumer accepts result
//   res_q      product Q (registered)
//   res_id     index of the requester that produced res_q (registered)
//   done_cnt   count of consumed results, wraps (registered)
//   busy       a result is held or an operand is pending

// Shared-factor GF(2^2) multiplier.
module gf_muls_2 (
  input  logic [1:0] a,
  input  logic       ab,
  input  logic [1:0] b,
  input  logic       cd,
  output logic [1:0] q
);

  logic abcd;

  assign abcd = ~(ab & cd);
  assign q[1] = ~(a[1] & b[1]) ^ abcd;
  assign q[0] = ~(a[0] & b[0]) ^ abcd;

endmodule

module gf_muls_2_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_a,
  input  logic [NREQ-1:0]   req_ab,
  input  logic [2*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_cd,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        res_q,
  output logic [IDW-1:0]    res_id,
  output logic [CNTW-1:0]   done_cnt,
  output logic              busy
);

  // STALL is FULL with res_ready low; it needs no state of its own because
  // the grant logic already suppresses grants when the slot is not free.
  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t         state;
  logic           free_c;
  logic           gnt_any_c;
  logic [IDW-1:0] gnt_id_c;
  logic [IDW-1:0] idx;
  logic [1:0]     sel_a;
  logic [1:0]     sel_b;
  logic           sel_ab;
  logic           sel_cd;
  logic [1:0]     prod;
`ifndef GF_MULS_2_SCHED_FIXED_PRIO_EN
  logic [IDW-1:0] ptr;
  logic [IDW:0]   sum;
`endif

  assign res_valid = (state == FULL);
  assign free_c    = !res_valid || res_ready;
  assign busy      = res_valid | (|req_valid);

  // Grant search: the first valid requester starting at ptr (or at 0 in fixed
  // priority). It looks only at req_valid and never at a requester's data lines.
  always_comb begin
    gnt_any_c = 1'b0;
    gnt_id_c  = '0;
    idx       = '0;
`ifndef GF_MULS_2_SCHED_FIXED_PRIO_EN
    sum       = '0;
`endif
    for (int k = 0; k < NREQ; k++) begin
`ifdef GF_MULS_2_SCHED_FIXED_PRIO_EN
      idx = IDW'(k);
`else
      sum = (IDW+1)'(ptr) + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = IDW'(sum);
`endif
      if (!gnt_any_c && req_valid[idx]) begin
        gnt_any_c = 1'b1;
        gnt_id_c  = idx;
      end
    end
    // Hold req_ready at its reset value while reset is asserted.
    if (rst || !free_c) gnt_any_c = 1'b0;
  end

  assign req_ready = gnt_any_c ? (NREQ'(1) << gnt_id_c) : '0;

  // Operand mux feeding the single shared multiplier.
  assign sel_a  = req_a[2*gnt_id_c +: 2];
  assign sel_b  = req_b[2*gnt_id_c +: 2];
  assign sel_ab = req_ab[gnt_id_c];
  assign sel_cd = req_cd[gnt_id_c];

  gf_muls_2 u_mul (
    .a  (sel_a),
    .ab (sel_ab),
    .b  (sel_b),
    .cd (sel_cd),
    .q  (prod)
  );

  // Result slot FSM, registered outputs and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      res_q    <= '0;
      res_id   <= '0;
      done_cnt <= '0;
`ifndef GF_MULS_2_SCHED_FIXED_PRIO_EN
      ptr      <= '0;
`endif
    end else begin
      if (res_valid && res_ready) done_cnt <= done_cnt + CNTW'(1);
      if (gnt_any_c) begin
        // A new result replaces a consumed one with no bubble.
        state  <= FULL;
        res_q  <= prod;
        res_id <= gnt_id_c;
`ifndef GF_MULS_2_SCHED_FIXED_PRIO_EN
        ptr    <= (gnt_id_c == IDW'(NREQ - 1)) ? '0 : gnt_id_c + IDW'(1);
`endif
      end else if (res_valid && res_ready) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_gf_muls_2_sched.sv
// Self-checking bench for gf_muls_2_sched: directed steps followed by random traffic,
// checked against a transaction-level model. CNTW is shrunk to 4 to reach the wrap quickly.
module tb_gf_muls_2_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned CNTW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_a;
  logic [NREQ-1:0]   req_ab;
  logic [2*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_cd;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_q;
  logic [IDW-1:0]    res_id;
  logic [CNTW-1:0]   done_cnt;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  bit         m_valid;
  logic [1:0] m_q;
  int         m_id;
  int         m_cnt;
  int         m_ptr;
  int         m_gnt;

  gf_muls_2_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_ab    (req_ab),
    .req_b     (req_b),
    .req_cd    (req_cd),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_q     (res_q),
    .res_id    (res_id),
    .done_cnt  (done_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Product from the multiplication rules, with each NAND computed arithmetically.
  function automatic logic [1:0] mprod(input int i);
    int a, b, nabcd, q1, q0;
    a     = int'(req_a[2*i +: 2]);
    b     = int'(req_b[2*i +: 2]);
    nabcd = (req_ab[i] && req_cd[i]) ? 0 : 1;
    q1    = ((((a / 2) % 2) * ((b / 2) % 2)) == 1 ? 0 : 1) ^ nabcd;
    q0    = (((a % 2) * (b % 2)) == 1 ? 0 : 1) ^ nabcd;
    return 2'(q1 * 2 + q0);
  endfunction

  function automatic int mgrant();
    int idx;
    if (m_valid && !res_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
`ifdef GF_MULS_2_SCHED_FIXED_PRIO_EN
      idx = k;
`else
      idx = (m_ptr + k) % NREQ;
`endif
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_q = 2'b00; m_id = 0; m_cnt = 0; m_ptr = 0;
  endtask

  // One clock: inputs are already driven at posedge+1. The combinational grant is
  // checked mid-cycle and the registered outputs just after the next edge.
  task automatic cycle();
    #4;
    m_gnt = mgrant();
    chk("req_ready", 32'(req_ready), (m_gnt < 0) ? 32'd0 : (32'd1 << m_gnt));
    chk("busy", 32'(busy), 32'(m_valid | (|req_valid)));
    @(posedge clk);
    if (m_valid && res_ready) m_cnt = (m_cnt + 1) % (1 << CNTW);
    if (m_gnt >= 0) begin
      m_q = mprod(m_gnt); m_id = m_gnt; m_valid = 1'b1; m_ptr = (m_gnt + 1) % NREQ;
    end else if (m_valid && res_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    if (m_valid) begin
      chk("res_q", 32'(res_q), 32'(m_q));
      chk("res_id", 32'(res_id), 32'(m_id));
    end
    chk("done_cnt", 32'(done_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_ab = '0; req_b = '0; req_cd = '0;
    res_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_q", 32'(res_q), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single op on requester 0: Q = 00.
    req_valid = 4'b0001; req_a = 8'b0000_0011; req_b = 8'b0000_0011;
    req_ab = 4'b0001; req_cd = 4'b0001; res_ready = 1'b1;
    cycle();
    chk("single_q", 32'(res_q), 32'd0);
    chk("single_id", 32'(res_id), 32'd0);
    req_valid = '0;
    cycle();
    chk("single_cnt", 32'(done_cnt), 32'd1);

    // Shared-factor checks on requester 2.
    req_valid = 4'b0100; req_a = 8'b0010_0000; req_b = 8'b0010_0000;
    req_ab = 4'b0100; req_cd = 4'b0000;
    cycle();
    chk("shared_q10", 32'(res_q), 32'd2);
    chk("shared_id2", 32'(res_id), 32'd2);
    req_a = 8'b0011_0000; req_b = 8'b0011_0000; req_ab = 4'b0000;
    cycle();
    chk("shared_q11", 32'(res_q), 32'd3);
    req_valid = '0;
    cycle();

    // Round robin from ptr 0 with every requester valid.
    do_reset();
    req_valid = 4'b1111; res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
`ifdef GF_MULS_2_SCHED_FIXED_PRIO_EN
      chk("rr_id", 32'(res_id), 32'd0);
`else
      chk("rr_id", 32'(res_id), 32'(i % NREQ));
`endif
      chk("rr_nobubble", 32'(res_valid), 32'd1);
    end

    // Backpressure: the result is held while req1 waits.
    req_valid = 4'b0010; res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    cycle();
    chk("bp_release_id", 32'(res_id), 32'd1);
    req_valid = '0;
    cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
      req_ab = 4'($urandom); req_cd = 4'($urandom);
      res_ready = ($urandom_range(3) != 0);
      cycle();
    end

    // done_cnt wraps at 2^CNTW.
    do_reset();
    req_valid = 4'b0001; res_ready = 1'b1;
    for (int i = 0; i < 16; i++) cycle();
    chk("wrap_pre", 32'(done_cnt), 32'd15);
    req_valid = '0;
    cycle();
    chk("wrap_zero", 32'(done_cnt), 32'd0);

    // An asynchronous reset mid-operation drops the pending result at once.
    req_valid = 4'b0100; req_a = 8'hff; req_b = 8'hff; req_ab = '0; req_cd = '0;
    cycle();
    req_valid = '0; res_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_res_q", 32'(res_q), 32'd0);
    chk("arst_res_id", 32'(res_id), 32'd0);
    chk("arst_done_cnt", 32'(done_cnt), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'b0110; res_ready = 1'b1;
    cycle();
    chk("arst_next_id", 32'(res_id), 32'd1);
    req_valid = '0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
